// File: rtl/tail_light_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// tail_light_sequencer_pkg : state codes and state classification helpers
// Revision: 1.0
// ============================================================================
package tail_light_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_HAZARD  = 4'd1,
    S_BRAKE   = 4'd3,
    S_TURN_R  = 4'd4,
    S_TURN_L  = 4'd5,
    S_BTURN_R = 4'd6,
    S_BTURN_L = 4'd7
  } state_t;

  function automatic logic is_legal(input state_t s);
    case (s)
      S_IDLE, S_HAZARD, S_BRAKE, S_TURN_R, S_TURN_L, S_BTURN_R, S_BTURN_L: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_turn(input state_t s);
    is_turn = (s == S_TURN_R) || (s == S_TURN_L) || (s == S_BTURN_R) || (s == S_BTURN_L);
  endfunction

  function automatic logic is_left(input state_t s);
    is_left = (s == S_TURN_L) || (s == S_BTURN_L);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tail_light_sequencer_blink_timer.sv
`default_nettype none
// ============================================================================
// blink_timer : free-running animation step divider with synchronous clear
// Revision: 1.0
// ============================================================================
module blink_timer #(
  parameter int TICK_DIV = 25_000_000,
  parameter int DIV_W    = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_W-1:0] C_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear || (count_q == C_LAST)) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tick = (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/tail_light_sequencer.sv
`default_nettype none
// ============================================================================
// tail_light_sequencer : turn/hazard/brake tail-light controller with chase
// Revision: 1.0
// ============================================================================
module tail_light_sequencer
  import tail_light_sequencer_pkg::*;
#(
  parameter int LAMPS_PER_SIDE = 3,
  parameter int TICK_DIV       = 25_000_000,
  parameter int DIV_W          = 25
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hazard_sw,
  input  logic                      turn_sw,
  input  logic                      brake_sw,
  input  logic                      dir_left,
  output logic [LAMPS_PER_SIDE-1:0] lamps_l,
  output logic [LAMPS_PER_SIDE-1:0] lamps_r,
  output logic [3:0]                state_o,
  output logic                      tick_o
);

  localparam int                            C_STEP_W   = $clog2(LAMPS_PER_SIDE + 1);
  localparam logic [C_STEP_W-1:0]           C_STEP_MAX = C_STEP_W'(LAMPS_PER_SIDE);
  localparam logic [LAMPS_PER_SIDE-1:0]     C_ALL_ON   = '1;

  state_t                    state_q, state_d;
  logic [C_STEP_W-1:0]       step_q;
  logic                      hz_q;
  logic [LAMPS_PER_SIDE-1:0] lamps_l_q, lamps_r_q;
  logic [LAMPS_PER_SIDE-1:0] lamps_l_d, lamps_r_d;
  logic [LAMPS_PER_SIDE-1:0] therm_d;
  logic                      restart_d;
  logic                      tick_d;

  always_comb begin
    state_d = S_IDLE;
    if (!is_legal(state_q))          state_d = S_IDLE;
    else if (hazard_sw)              state_d = S_HAZARD;
    else if (brake_sw && turn_sw)    state_d = dir_left ? S_BTURN_L : S_BTURN_R;
    else if (brake_sw)               state_d = S_BRAKE;
    else if (turn_sw)                state_d = dir_left ? S_TURN_L : S_TURN_R;
  end

  assign restart_d = (state_d != state_q);

  blink_timer #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_blink_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (restart_d),
    .tick  (tick_d)
  );

  always_comb begin
    therm_d = '0;
    for (int i = 0; i < LAMPS_PER_SIDE; i++) begin
      if (i < int'(step_q)) therm_d[i] = 1'b1;
    end
  end

  // Decode from the registered state so lamps lag the state register by one clk.
  always_comb begin
    lamps_l_d = '0;
    lamps_r_d = '0;
    case (state_q)
      S_HAZARD: begin
        lamps_l_d = hz_q ? C_ALL_ON : '0;
        lamps_r_d = hz_q ? C_ALL_ON : '0;
      end
      S_BRAKE: begin
        lamps_l_d = C_ALL_ON;
        lamps_r_d = C_ALL_ON;
      end
      S_TURN_L:  lamps_l_d = therm_d;
      S_TURN_R:  lamps_r_d = therm_d;
      S_BTURN_L: begin
        lamps_l_d = therm_d;
        lamps_r_d = C_ALL_ON;
      end
      S_BTURN_R: begin
        lamps_l_d = C_ALL_ON;
        lamps_r_d = therm_d;
      end
      default: begin
        lamps_l_d = '0;
        lamps_r_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      hz_q      <= 1'b0;
      lamps_l_q <= '0;
      lamps_r_q <= '0;
    end else begin
      state_q   <= state_d;
      lamps_l_q <= lamps_l_d;
      lamps_r_q <= lamps_r_d;
      if (restart_d) begin
        step_q <= '0;
        hz_q   <= 1'b1;
      end else begin
        if (is_turn(state_q) && tick_d) begin
          step_q <= (step_q == C_STEP_MAX) ? '0 : step_q + 1'b1;
        end
        if ((state_q == S_HAZARD) && tick_d) begin
          hz_q <= ~hz_q;
        end
      end
    end
  end

  assign lamps_l = lamps_l_q;
  assign lamps_r = lamps_r_q;
  assign state_o = state_q;
  assign tick_o  = tick_d;

endmodule
`default_nettype wire

// File: tb/tb_tail_light_sequencer.sv
`default_nettype none
// ============================================================================
// tb_tail_light_sequencer : directed self-checking bench, N=3, TICK_DIV=4
// Revision: 1.0
// ============================================================================
module tb_tail_light_sequencer;

  localparam int C_N  = 3;
  localparam int C_TD = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           hazard_sw, turn_sw, brake_sw, dir_left;
  logic [C_N-1:0] lamps_l, lamps_r;
  logic [3:0]     state_o;
  logic           tick_o;

  int n_checks = 0;
  int n_fail   = 0;

  tail_light_sequencer #(
    .LAMPS_PER_SIDE (C_N),
    .TICK_DIV       (C_TD),
    .DIV_W          (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hazard_sw (hazard_sw),
    .turn_sw   (turn_sw),
    .brake_sw  (brake_sw),
    .dir_left  (dir_left),
    .lamps_l   (lamps_l),
    .lamps_r   (lamps_r),
    .state_o   (state_o),
    .tick_o    (tick_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  function automatic logic [7:0] th(input int k);
    th = 8'((1 << k) - 1);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hazard_sw = 1'b0; turn_sw = 1'b0; brake_sw = 1'b0; dir_left = 1'b1;
    #12;
    chk("rst_lamps_l", 8'(lamps_l), 8'h00);
    chk("rst_lamps_r", 8'(lamps_r), 8'h00);
    chk("rst_state",   8'(state_o), 8'h00);
    chk("rst_tick",    8'(tick_o),  8'h00);
    @(negedge clk);
    rst = 1'b0;

    // tick_o pulses on the 3rd, 7th ... edge after reset release
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      chk("idle_tick", 8'(tick_o), (k % 4 == 3) ? 8'h01 : 8'h00);
    end

    brake_sw = 1'b1;
    cyc(1);
    chk("brake_state", 8'(state_o), 8'h03);
    cyc(1);
    chk("brake_l", 8'(lamps_l), 8'h07);
    chk("brake_r", 8'(lamps_r), 8'h07);
    brake_sw = 1'b0;
    cyc(2);
    chk("unbrake_state", 8'(state_o), 8'h00);
    chk("unbrake_l",     8'(lamps_l), 8'h00);

    // left chase: lamps lag the state register by one clk
    turn_sw = 1'b1; dir_left = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      cyc(1);
      if (k == 1) chk("turnl_state", 8'(state_o), 8'h05);
      if (k >= 2) begin
        chk("turnl_l", 8'(lamps_l), th(((k - 2) / 4) % 4));
        chk("turnl_r", 8'(lamps_r), 8'h00);
      end
    end
    cyc(5);
    chk("turnl_step2", 8'(lamps_l), 8'h03);

    dir_left = 1'b0;
    cyc(1);
    chk("dirflip_state", 8'(state_o), 8'h04);
    cyc(1);
    chk("dirflip_l", 8'(lamps_l), 8'h00);
    chk("dirflip_r", 8'(lamps_r), 8'h00);
    cyc(4);
    chk("turnr_r1", 8'(lamps_r), 8'h01);
    chk("turnr_l1", 8'(lamps_l), 8'h00);

    brake_sw = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      cyc(1);
      if (k == 1) chk("bturnr_state", 8'(state_o), 8'h06);
      if (k >= 2 && ((k - 2) % 4) == 0) begin
        chk("bturnr_l", 8'(lamps_l), 8'h07);
        chk("bturnr_r", 8'(lamps_r), th(((k - 2) / 4) % 4));
      end
    end

    hazard_sw = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      cyc(1);
      if (k == 1) chk("haz_state", 8'(state_o), 8'h01);
      if (k == 4) chk("haz_tick",  8'(tick_o),  8'h01);
      if (k >= 2) begin
        chk("haz_l", 8'(lamps_l), ((((k - 2) / 4) % 2) == 0) ? 8'h07 : 8'h00);
        chk("haz_r", 8'(lamps_r), ((((k - 2) / 4) % 2) == 0) ? 8'h07 : 8'h00);
      end
    end

    hazard_sw = 1'b0; brake_sw = 1'b0; turn_sw = 1'b0;
    cyc(1);
    chk("off_state", 8'(state_o), 8'h00);

    // illegal code must fall back to IDLE even with a turn request pending
    turn_sw = 1'b1; dir_left = 1'b1;
    force dut.state_q = tail_light_sequencer_pkg::state_t'(4'd2);
    #1;
    chk("forced_state", 8'(state_o), 8'h02);
    release dut.state_q;
    cyc(1);
    chk("illegal_idle", 8'(state_o), 8'h00);
    cyc(1);
    chk("illegal_turnl", 8'(state_o), 8'h05);
    cyc(7);
    chk("midchase_l", 8'(lamps_l), 8'h01);

    #2;
    rst = 1'b1;
    #1;
    chk("arst_l",     8'(lamps_l), 8'h00);
    chk("arst_r",     8'(lamps_r), 8'h00);
    chk("arst_state", 8'(state_o), 8'h00);
    chk("arst_tick",  8'(tick_o),  8'h00);
    turn_sw = 1'b0;
    cyc(2);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk("post_rst_tick", 8'(tick_o), (k == 3) ? 8'h01 : 8'h00);
    end
    chk("post_rst_state", 8'(state_o), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
